// File: rtl/gpio_bank_if.sv
// ---------------------------------------------------------------------------
// gpio_bank_if -- register port between the bus bridge and gpio_bank.
//
// This is a simple single-cycle register port:
//   reg_addr   3-bit register select.
//   reg_wr     write strobe, one cycle per write.
//   reg_rd     read strobe, one cycle per read.
//   reg_wdata  write data.
//   reg_rdata  read data. It is registered and holds until the next read.
//   reg_rvalid high for the one cycle after a read strobe.
//
// Modports:
//   master  the bus bridge (or the testbench).
//   slave   the GPIO block.
// ---------------------------------------------------------------------------
interface gpio_bank_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       reg_addr;
  logic             reg_wr;
  logic             reg_rd;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;
  logic             reg_rvalid;

  modport master (
    output reg_addr, reg_wr, reg_rd, reg_wdata,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_addr, reg_wr, reg_rd, reg_wdata,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/gpio_bank.sv
// ---------------------------------------------------------------------------
// gpio_bank -- parametrised GPIO controller.
//
// Each pin has the following:
//   - an output value register and a direction register. These drive
//     gpio_o and gpio_oe, and the pads are tristated outside this block.
//   - a SYNC_STAGES-deep input synchroniser.
//   - a debounce filter. A new level is accepted after DB_LIMIT+1
//     consecutive mismatching cycles.
//   - rising and falling edge events. They set STATUS, which is
//     write-1-to-clear. irq is the registered OR of STATUS.
//
// Ports:
//   HCLK     sole clock. All flops are rising-edge.
//   hwRstn   synchronous active-low reset.
//   bus      register port (gpio_bank_if.slave).
//   gpio_i   asynchronous pad inputs.
//   gpio_o   pad output values (the OUT register).
//   gpio_oe  pad output enables, 1 = drive (the DIR register).
//   irq      level interrupt.
//
// Register map:
//   0 OUT       1 DIR       2 IN (RO)      3 RISE_EN
//   4 FALL_EN   5 STATUS (W1C)             6 DB_LIMIT (DB_W bits)
//   7 reserved (reads 0)
// SYNC_STAGES must be in the range 2..4.
// ---------------------------------------------------------------------------
module gpio_bank #(
  parameter int              WIDTH       = 16,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_W        = 8,
  parameter logic [DB_W-1:0] DB_RESET    = '0
) (
  input  logic              HCLK,
  input  logic              hwRstn,
  gpio_bank_if.slave        bus,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  typedef enum logic [2:0] {
    A_OUT     = 3'd0,
    A_DIR     = 3'd1,
    A_IN      = 3'd2,
    A_RISE_EN = 3'd3,
    A_FALL_EN = 3'd4,
    A_STATUS  = 3'd5,
    A_DB      = 3'd6,
    A_RSVD    = 3'd7
  } reg_addr_e;

  localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

  reg_addr_e        addr;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [DB_W-1:0]  db_limit_q;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt_q;
  logic [DB_W-1:0]  cnt_q [WIDTH];

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rd_mux;

  assign addr    = reg_addr_e'(bus.reg_addr);
  assign sync    = sync_q[SYNC_STAGES-1];
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

  // ---------------------------------------------------------------------------
  // Debounce decision and edge events.
  // An event fires on the same edge that filt takes the new level.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync[i] != filt_q[i]) && (cnt_q[i] >= db_limit_q);
    end
    rise_evt = accept &  sync & rise_en_q;
    fall_evt = accept & ~sync & fall_en_q;
    w1c_mask = (bus.reg_wr && addr == A_STATUS) ? bus.reg_wdata : '0;
  end

  // ---------------------------------------------------------------------------
  // Read mux. It samples the registers before a write on the same edge,
  // so a simultaneous read and write returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:     rd_mux = out_q;
      A_DIR:     rd_mux = dir_q;
      A_IN:      rd_mux = filt_q;
      A_RISE_EN: rd_mux = rise_en_q;
      A_FALL_EN: rd_mux = fall_en_q;
      A_STATUS:  rd_mux = status_q;
      A_DB:      rd_mux[DB_W-1:0] = db_limit_q;
      default:   rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser chain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!hwRstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce filter.
  // The counter only advances while sync differs from filt. The >= compare
  // stops it from wrapping if DB_LIMIT is lowered while a count is running.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!hwRstn) begin
      filt_q <= '0;
      // NOTE: the counter array is reset explicitly, so a reset mid-count discards the pending count.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          filt_q[i] <= sync[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i]  <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file, STATUS, irq and read port.
  // When an event and a W1C hit the same bit on the same edge, the set wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!hwRstn) begin
      out_q          <= '0;
      dir_q          <= '0;
      rise_en_q      <= '0;
      fall_en_q      <= '0;
      status_q       <= '0;
      db_limit_q     <= DB_RESET;
      irq            <= 1'b0;
      bus.reg_rdata  <= '0;
      bus.reg_rvalid <= 1'b0;
    end else begin
      if (bus.reg_wr) begin
        case (addr)
          A_OUT:     out_q      <= bus.reg_wdata;
          A_DIR:     dir_q      <= bus.reg_wdata;
          A_RISE_EN: rise_en_q  <= bus.reg_wdata;
          A_FALL_EN: fall_en_q  <= bus.reg_wdata;
          A_DB:      db_limit_q <= bus.reg_wdata[DB_W-1:0];
          default:   ;
        endcase
      end
      status_q       <= (status_q & ~w1c_mask) | rise_evt | fall_evt;
      irq            <= |status_q;
      bus.reg_rvalid <= bus.reg_rd;
      if (bus.reg_rd) bus.reg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// ---------------------------------------------------------------------------
// tb_gpio_bank -- directed self-checking bench for gpio_bank.
// Inputs are driven 1 time unit after a rising edge, and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_gpio_bank;
  localparam int WIDTH = 16;

  logic             HCLK = 1'b0;
  logic             hwRstn = 1'b0;
  logic [WIDTH-1:0] gpio_i = '0;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  int vectors = 0;
  int errors  = 0;

  always #5 HCLK = ~HCLK;

  gpio_bank_if #(.WIDTH(WIDTH)) bus ();

  gpio_bank #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .DB_W(8), .DB_RESET(8'h00)
  ) dut (
    .HCLK    (HCLK),
    .hwRstn  (hwRstn),
    .bus     (bus.slave),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_wr    = 1'b1;
    tick();
    bus.reg_wr    = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [WIDTH-1:0] d, output logic v);
    bus.reg_addr = a;
    bus.reg_rd   = 1'b1;
    tick();
    bus.reg_rd   = 1'b0;
    d = bus.reg_rdata;
    v = bus.reg_rvalid;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] d;
    logic             v;
    gpio_i = 16'hFFFF;
    hwRstn = 1'b0;
    repeat (3) tick();
    hwRstn = 1'b1;
    vectors++; if (gpio_oe !== 16'h0000) begin errors++; $display("FAIL reset_oe got=%h exp=0000", gpio_oe); end
    vectors++; if (gpio_o !== 16'h0000) begin errors++; $display("FAIL reset_o got=%h exp=0000", gpio_o); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    vectors++; if (bus.reg_rvalid !== 1'b0 || bus.reg_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rport rvalid=%b rdata=%h exp 0/0000", bus.reg_rvalid, bus.reg_rdata);
    end
    do_read(3'd0, d, v);
    vectors++; if (d !== 16'h0000 || v !== 1'b1) begin errors++; $display("FAIL reset_out got=%h v=%b exp=0000 v=1", d, v); end
    do_read(3'd1, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_dir got=%h exp=0000", d); end
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got=%h exp=0000", d); end
    repeat (3) tick();
    do_read(3'd2, d, v);
    vectors++; if (d !== 16'hFFFF) begin errors++; $display("FAIL reset_in got=%h exp=ffff", d); end
  endtask

  task automatic test_out_dir();
    logic [WIDTH-1:0] d;
    logic             v;
    gpio_i = '0;
    do_write(3'd1, 16'h00FF);
    vectors++; if (gpio_oe !== 16'h00FF) begin errors++; $display("FAIL dir_pin got=%h exp=00ff", gpio_oe); end
    do_write(3'd0, 16'hA5A5);
    vectors++; if (gpio_o !== 16'hA5A5) begin errors++; $display("FAIL out_pin got=%h exp=a5a5", gpio_o); end
    do_read(3'd1, d, v);
    vectors++; if (d !== 16'h00FF || v !== 1'b1) begin errors++; $display("FAIL dir_read got=%h v=%b exp=00ff v=1", d, v); end
    tick();
    vectors++; if (bus.reg_rvalid !== 1'b0 || bus.reg_rdata !== 16'h00FF) begin
      errors++; $display("FAIL rvalid_pulse rvalid=%b rdata=%h exp 0/00ff", bus.reg_rvalid, bus.reg_rdata);
    end
    do_read(3'd0, d, v);
    vectors++; if (d !== 16'hA5A5) begin errors++; $display("FAIL out_read got=%h exp=a5a5", d); end
  endtask

  task automatic test_regmap();
    logic [WIDTH-1:0] d;
    logic             v;
    do_write(3'd6, 16'h1204);
    do_read(3'd6, d, v);
    vectors++; if (d !== 16'h0004) begin errors++; $display("FAIL db_limit_width got=%h exp=0004", d); end
    do_write(3'd7, 16'hFFFF);
    do_read(3'd7, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reserved got=%h exp=0000", d); end
    // A read and a write on the same cycle return the value from before the write.
    bus.reg_addr = 3'd3; bus.reg_wdata = 16'h00F0; bus.reg_wr = 1'b1; bus.reg_rd = 1'b1;
    tick();
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    vectors++; if (bus.reg_rdata !== 16'h0000) begin errors++; $display("FAIL rd_wr_same got=%h exp=0000", bus.reg_rdata); end
    do_read(3'd3, d, v);
    vectors++; if (d !== 16'h00F0) begin errors++; $display("FAIL rd_wr_after got=%h exp=00f0", d); end
    do_write(3'd3, 16'h0000);
  endtask

  task automatic test_debounce();
    logic [WIDTH-1:0] d;
    logic             v;
    // DB_LIMIT is already 4. A 4-cycle glitch is too short and is rejected.
    gpio_i[3] = 1'b1;
    repeat (4) tick();
    gpio_i[3] = 1'b0;
    repeat (10) tick();
    do_read(3'd2, d, v);
    vectors++; if (d[3] !== 1'b0) begin errors++; $display("FAIL glitch_reject got=%b exp=0", d[3]); end
    // The level is held. filt updates on the 7th edge after the pad change,
    // and a continuous read shows it one edge later.
    bus.reg_addr = 3'd2;
    bus.reg_rd   = 1'b1;
    gpio_i[3]    = 1'b1;
    repeat (7) tick();
    vectors++; if (bus.reg_rdata[3] !== 1'b0 || bus.reg_rvalid !== 1'b1) begin
      errors++; $display("FAIL db_early got=%b v=%b exp=0 v=1", bus.reg_rdata[3], bus.reg_rvalid);
    end
    tick();
    vectors++; if (bus.reg_rdata[3] !== 1'b1) begin errors++; $display("FAIL db_accept got=%b exp=1", bus.reg_rdata[3]); end
    bus.reg_rd = 1'b0;
    tick();
  endtask

  task automatic test_edge_irq();
    logic [WIDTH-1:0] d;
    logic             v;
    do_write(3'd6, 16'h0000);
    gpio_i = 16'h000A;
    repeat (5) tick();
    do_write(3'd3, 16'h0001);
    do_write(3'd4, 16'h0002);
    do_write(3'd5, 16'hFFFF);
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_pre_status got=%h exp=0000", d); end
    gpio_i = 16'h0009;
    repeat (3) tick();
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_yet got=%b exp=0", irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0003) begin errors++; $display("FAIL status_both got=%h exp=0003", d); end
    do_write(3'd5, 16'h0001);
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0002) begin errors++; $display("FAIL status_w1c got=%h exp=0002", d); end
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq); end
    do_write(3'd5, 16'h0002);
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag got=%b exp=1", irq); end
    tick();
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] d;
    logic             v;
    gpio_i[0] = 1'b0;
    repeat (5) tick();
    do_write(3'd5, 16'hFFFF);
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL coll_pre got=%h exp=0000", d); end
    // The rising event lands on the 3rd edge, which is the same edge as the W1C write.
    gpio_i[0] = 1'b1;
    tick();
    tick();
    do_write(3'd5, 16'h0001);
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0001) begin errors++; $display("FAIL coll_set_wins got=%h exp=0001", d); end
    do_write(3'd5, 16'h0001);
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL coll_clear got=%h exp=0000", d); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d;
    logic             v;
    do_write(3'd6, 16'h000A);
    gpio_i[5] = 1'b1;
    repeat (5) tick();
    hwRstn = 1'b0;
    gpio_i = '0;
    tick();
    tick();
    hwRstn = 1'b1;
    vectors++; if (gpio_oe !== 16'h0000 || gpio_o !== 16'h0000 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_outputs oe=%h o=%h irq=%b exp 0000/0000/0", gpio_oe, gpio_o, irq);
    end
    do_read(3'd6, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_db_limit got=%h exp=0000", d); end
    do_read(3'd2, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_in got=%h exp=0000", d); end
    do_read(3'd5, d, v);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_status got=%h exp=0000", d); end
  endtask

  initial begin
    bus.reg_addr  = '0;
    bus.reg_wr    = 1'b0;
    bus.reg_rd    = 1'b0;
    bus.reg_wdata = '0;
    #1;
    test_reset();
    test_out_dir();
    test_regmap();
    test_debounce();
    test_edge_irq();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
